// File: rtl/motor_seq_pkg.sv
// ============================================================================
// motor_seq_pkg : shared types and ramp arithmetic for motor_cmd_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package motor_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_HOLD  = 3'd2,
    S_DECEL = 3'd3,
    S_HALT  = 3'd4
  } seq_state_t;

  typedef logic signed [31:0] rot_v_t;
  typedef logic [15:0]        step_t;

  function automatic int calc_tick_div(input int clk_freq, input int tick_hz);
    return clk_freq / tick_hz;
  endfunction

  // Moves cur toward goal by at most step; the 33-bit difference cannot overflow.
  function automatic rot_v_t clamp_step(input rot_v_t cur, input rot_v_t goal, input step_t step);
    logic signed [32:0] diff;
    logic signed [32:0] mag;
    logic signed [32:0] step_x;
    rot_v_t             step_s;
    diff   = {goal[31], goal} - {cur[31], cur};
    mag    = diff[32] ? -diff : diff;
    step_x = $signed({17'd0, step});
    step_s = $signed({16'd0, step});
    if (mag <= step_x) begin
      return goal;
    end
    return diff[32] ? (cur - step_s) : (cur + step_s);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// tick_gen : free-running prescaler, one-cycle strobe every DIV clocks
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk200M,
  input  logic rstn,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk200M) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/motor_cmd_sequencer.sv
// ============================================================================
// motor_cmd_sequencer : slew-limited L/R setpoints with watchdog and estop
// Rev 1.0
// ============================================================================
`default_nettype none

module motor_cmd_sequencer
  import motor_seq_pkg::*;
#(
  parameter int CLK_FREQ     = 200_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int DEFAULT_STEP = 16,
  parameter int WDT_TICKS    = 200
) (
  input  logic        clk200M,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_r_target,
  input  logic [31:0] cmd_l_target,
  input  logic [15:0] cmd_step,
  input  logic        estop,
  output logic [31:0] r_target_rot_v,
  output logic [31:0] l_target_rot_v,
  output logic [2:0]  seq_state,
  output logic        busy,
  output logic        wdt_expired
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, TICK_HZ);
  localparam int WDT_W    = $clog2(WDT_TICKS + 1);
  localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(WDT_TICKS);
  localparam step_t DEF_STEP = step_t'(DEFAULT_STEP);

  seq_state_t       state_q, state_d;
  rot_v_t           r_cur_q, r_cur_d, l_cur_q, l_cur_d;
  rot_v_t           r_goal_q, r_goal_d, l_goal_q, l_goal_d;
  step_t            step_q, step_d;
  logic [WDT_W-1:0] wdt_q, wdt_d, wdt_inc;
  logic             wdt_exp_q, wdt_exp_d;
  logic             tick;
  logic             accept;
  rot_v_t           r_next, l_next;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk200M (clk200M),
    .rstn    (rstn),
    .tick    (tick)
  );

  assign cmd_ready = ((state_q == S_IDLE) || (state_q == S_RAMP) || (state_q == S_HOLD)) && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign r_next    = clamp_step(r_cur_q, r_goal_q, step_q);
  assign l_next    = clamp_step(l_cur_q, l_goal_q, step_q);
  assign wdt_inc   = wdt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    r_cur_d   = r_cur_q;
    l_cur_d   = l_cur_q;
    r_goal_d  = r_goal_q;
    l_goal_d  = l_goal_q;
    step_d    = step_q;
    wdt_d     = wdt_q;
    wdt_exp_d = wdt_exp_q;

    if (estop) begin
      state_d  = S_HALT;
      r_cur_d  = '0;
      l_cur_d  = '0;
      r_goal_d = '0;
      l_goal_d = '0;
      wdt_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          r_cur_d = '0;
          l_cur_d = '0;
        end
        S_RAMP: begin
          if (tick) begin
            r_cur_d = r_next;
            l_cur_d = l_next;
            if ((r_next == r_goal_q) && (l_next == l_goal_q)) begin
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
        end
        S_DECEL: begin
          r_goal_d = '0;
          l_goal_d = '0;
          if ((r_cur_q == '0) && (l_cur_q == '0)) begin
            state_d = S_IDLE;
          end else if (tick) begin
            r_cur_d = r_next;
            l_cur_d = l_next;
            if ((r_next == '0) && (l_next == '0)) begin
              state_d = S_IDLE;
            end
          end
        end
        S_HALT: begin
          r_cur_d = '0;
          l_cur_d = '0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // Trip overrides the tick step's state change; an accept overrides the trip.
      if (tick && ((state_q == S_RAMP) || (state_q == S_HOLD))) begin
        wdt_d = wdt_inc;
        if (wdt_inc == WDT_LIMIT) begin
          wdt_d = '0;
          if ((r_goal_q != '0) || (l_goal_q != '0)) begin
            state_d   = S_DECEL;
            wdt_exp_d = 1'b1;
            r_goal_d  = '0;
            l_goal_d  = '0;
          end else begin
            state_d = S_IDLE;
            r_cur_d = '0;
            l_cur_d = '0;
          end
        end
      end

      if (accept) begin
        state_d   = S_RAMP;
        r_goal_d  = cmd_r_target;
        l_goal_d  = cmd_l_target;
        step_d    = (cmd_step == '0) ? DEF_STEP : cmd_step;
        wdt_d     = '0;
        wdt_exp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk200M) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      r_cur_q   <= '0;
      l_cur_q   <= '0;
      r_goal_q  <= '0;
      l_goal_q  <= '0;
      step_q    <= DEF_STEP;
      wdt_q     <= '0;
      wdt_exp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_cur_q   <= r_cur_d;
      l_cur_q   <= l_cur_d;
      r_goal_q  <= r_goal_d;
      l_goal_q  <= l_goal_d;
      step_q    <= step_d;
      wdt_q     <= wdt_d;
      wdt_exp_q <= wdt_exp_d;
    end
  end

  assign r_target_rot_v = r_cur_q;
  assign l_target_rot_v = l_cur_q;
  assign seq_state      = state_q;
  assign busy           = (state_q == S_RAMP) || (state_q == S_DECEL);
  assign wdt_expired    = wdt_exp_q;

endmodule

`default_nettype wire

// File: tb/tb_motor_cmd_sequencer.sv
// ============================================================================
// tb_motor_cmd_sequencer : directed self-checking bench for motor_cmd_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_motor_cmd_sequencer;

  logic        clk200M = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_r_target;
  logic [31:0] cmd_l_target;
  logic [15:0] cmd_step;
  logic        estop;
  logic [31:0] r_target_rot_v;
  logic [31:0] l_target_rot_v;
  logic [2:0]  seq_state;
  logic        busy;
  logic        wdt_expired;

  int tests = 0;
  int fails = 0;
  int pre   = 0;

  always #5 clk200M = ~clk200M;

  motor_cmd_sequencer #(
    .CLK_FREQ     (1000),
    .TICK_HZ      (100),
    .DEFAULT_STEP (16),
    .WDT_TICKS    (20)
  ) dut (
    .clk200M        (clk200M),
    .rstn           (rstn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_r_target   (cmd_r_target),
    .cmd_l_target   (cmd_l_target),
    .cmd_step       (cmd_step),
    .estop          (estop),
    .r_target_rot_v (r_target_rot_v),
    .l_target_rot_v (l_target_rot_v),
    .seq_state      (seq_state),
    .busy           (busy),
    .wdt_expired    (wdt_expired)
  );

  // Expected tick phase: divide-by-10 counter cleared by reset.
  always @(posedge clk200M) begin
    if (!rstn) pre <= 0;
    else       pre <= (pre == 9) ? 0 : pre + 1;
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk200M);
    #1;
  endtask

  task automatic wait_tick();
    int n   = 0;
    bit hit = 1'b0;
    while (!hit && n < 20) begin
      @(posedge clk200M);
      hit = (pre == 9);
      #1;
      n++;
    end
    if (!hit) begin
      fails++;
      $error("FAIL tick_timeout: observed no tick expected tick within 20 cycles");
    end
  endtask

  task automatic send_cmd(input logic signed [31:0] r, input logic signed [31:0] l, input logic [15:0] s);
    cmd_r_target = r;
    cmd_l_target = l;
    cmd_step     = s;
    cmd_valid    = 1'b1;
    cyc();
    cmd_valid    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rstn         = 1'b0;
    cmd_valid    = 1'b0;
    estop        = 1'b0;
    cmd_r_target = '0;
    cmd_l_target = '0;
    cmd_step     = '0;

    // Reset state
    repeat (3) cyc();
    check("rst_r", r_target_rot_v, 0);
    check("rst_l", l_target_rot_v, 0);
    check("rst_state", seq_state, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_wdt", wdt_expired, 0);
    check("rst_busy", busy, 0);
    rstn = 1'b1;

    // Command r=100, l=-50, step 16
    send_cmd(100, -50, 16);
    check("acc_state", seq_state, 1);
    check("acc_busy", busy, 1);
    for (int k = 1; k <= 7; k++) begin
      wait_tick();
      check($sformatf("ramp_r_%0d", k), r_target_rot_v, (16 * k > 100) ? 100 : 16 * k);
      check($sformatf("ramp_l_%0d", k), l_target_rot_v, (16 * k > 50) ? -50 : -16 * k);
      if (k == 6) check("ramp_state_6", seq_state, 1);
    end
    check("hold_state", seq_state, 2);
    check("hold_busy", busy, 0);

    // Reversal with step 0 -> default 16
    send_cmd(-100, -50, 0);
    for (int k = 1; k <= 13; k++) begin
      wait_tick();
      check($sformatf("rev_r_%0d", k), r_target_rot_v, (100 - 16 * k < -100) ? -100 : 100 - 16 * k);
      if (k == 12) check("rev_state_12", seq_state, 1);
    end
    check("rev_hold", seq_state, 2);
    check("rev_l", l_target_rot_v, -50);

    // Watchdog trip with nonzero goal
    send_cmd(100, 0, 16);
    for (int k = 1; k <= 19; k++) begin
      wait_tick();
      if (k == 13) begin
        check("wd_r_at_goal", r_target_rot_v, 100);
        check("wd_l_at_goal", l_target_rot_v, 0);
        check("wd_hold_13", seq_state, 2);
      end
    end
    check("wd_hold_19", seq_state, 2);
    check("wd_flag_19", wdt_expired, 0);
    wait_tick();
    check("wd_flag_20", wdt_expired, 1);
    check("wd_decel", seq_state, 3);
    check("wd_busy", busy, 1);
    check("wd_r_trip", r_target_rot_v, 100);
    cmd_r_target = 5;
    cmd_l_target = 5;
    cmd_step     = 16;
    cmd_valid    = 1'b1;
    check("wd_ready_low", cmd_ready, 0);
    cyc();
    cmd_valid = 1'b0;
    check("wd_ignored", seq_state, 3);
    for (int k = 1; k <= 7; k++) begin
      wait_tick();
      check($sformatf("decel_r_%0d", k), r_target_rot_v, (100 - 16 * k < 0) ? 0 : 100 - 16 * k);
    end
    check("decel_idle", seq_state, 0);
    check("decel_flag", wdt_expired, 1);

    // Next accept clears the flag; then estop at r=48
    send_cmd(100, 0, 16);
    check("clr_flag", wdt_expired, 0);
    check("clr_state", seq_state, 1);
    repeat (3) wait_tick();
    check("es_pre_r", r_target_rot_v, 48);
    estop = 1'b1;
    cyc();
    check("es_r", r_target_rot_v, 0);
    check("es_l", l_target_rot_v, 0);
    check("es_state", seq_state, 4);
    check("es_ready", cmd_ready, 0);
    estop = 1'b0;
    cyc();
    check("es_rel_state", seq_state, 0);
    check("es_rel_r", r_target_rot_v, 0);
    check("es_rel_ready", cmd_ready, 1);

    // Accept coinciding with a tick: step uses the old goal
    send_cmd(100, 0, 16);
    repeat (2) wait_tick();
    check("sim_pre_r", r_target_rot_v, 32);
    n = 0;
    while (pre != 9 && n < 20) begin
      cyc();
      n++;
    end
    cmd_r_target = 0;
    cmd_l_target = 0;
    cmd_step     = 16;
    cmd_valid    = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    check("sim_r_0", r_target_rot_v, 48);
    check("sim_state", seq_state, 1);
    for (int k = 1; k <= 3; k++) begin
      wait_tick();
      check($sformatf("sim_r_%0d", k), r_target_rot_v, 48 - 16 * k);
    end
    check("sim_hold", seq_state, 2);

    // Watchdog with zero goals returns to IDLE without the flag
    for (int k = 4; k <= 19; k++) wait_tick();
    check("wz_hold_19", seq_state, 2);
    wait_tick();
    check("wz_idle", seq_state, 0);
    check("wz_flag", wdt_expired, 0);

    // Reset mid-ramp
    send_cmd(100, -50, 16);
    wait_tick();
    check("mr_pre_r", r_target_rot_v, 16);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    check("mr_r", r_target_rot_v, 0);
    check("mr_l", l_target_rot_v, 0);
    check("mr_state", seq_state, 0);
    check("mr_busy", busy, 0);
    repeat (2) wait_tick();
    check("mr_r_after", r_target_rot_v, 0);
    check("mr_state_after", seq_state, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
